total_alu: RTL and testbench

Single-cycle MIPS-style ALU with an attached 32-cycle sequential unsigned divider and HI/LO result registers. It takes a 6-bit function code (MIPS R-type funct field) and two 32-bit operands, and drives one 32-bit result. Divide results are read back with MFHI/MFLO function codes. Sits in the execute stage of the datapath.

---
 rtl/total_alu_pkg.sv | 25 ++
 rtl/divu_seq.sv | 100 ++++++++++
 rtl/total_alu.sv | 62 ++++++
 tb/tb_total_alu.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/total_alu_pkg.sv
// Shared constants for the execute-stage ALU: function codes, widths and divider states.
package total_alu_pkg;

    localparam int unsigned WIDTH      = 32;
    localparam int unsigned DIV_CYCLES = 32;
    localparam int unsigned FN_W       = 6;
    localparam int unsigned SHAMT_W    = $clog2(WIDTH);

    localparam logic [FN_W-1:0] FN_AND  = 6'd36;
    localparam logic [FN_W-1:0] FN_OR   = 6'd37;
    localparam logic [FN_W-1:0] FN_ADD  = 6'd32;
    localparam logic [FN_W-1:0] FN_SUB  = 6'd34;
    localparam logic [FN_W-1:0] FN_SLT  = 6'd42;
    localparam logic [FN_W-1:0] FN_SRL  = 6'd2;
    localparam logic [FN_W-1:0] FN_DIVU = 6'd27;
    localparam logic [FN_W-1:0] FN_MFHI = 6'd16;
    localparam logic [FN_W-1:0] FN_MFLO = 6'd18;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/divu_seq.sv
// Restoring shift-subtract unsigned divider, one quotient bit per clock.
// done is high during the edge that retires the last iteration; quotient/remainder are that iteration's result.
module divu_seq
    import total_alu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int unsigned CNT_W = $clog2(DIV_CYCLES);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_CYCLES - 1);

    div_state_e       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_count, w_count_nxt;
    logic [WIDTH-1:0] r_rem, w_rem_nxt;
    logic [WIDTH-1:0] r_quo, w_quo_nxt;
    logic [WIDTH-1:0] r_div, w_div_nxt;

    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_step;
    logic [WIDTH-1:0] w_quo_step;

    // One restoring step: shift the next dividend bit into the partial remainder and trial-subtract.
    always_comb begin
        w_shift    = {r_rem, r_quo[WIDTH-1]};
        w_ge       = (w_shift >= {1'b0, r_div});
        w_rem_step = w_ge ? WIDTH'(w_shift - {1'b0, r_div}) : w_shift[WIDTH-1:0];
        w_quo_step = {r_quo[WIDTH-2:0], w_ge};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_rem   <= w_rem_nxt;
            r_quo   <= w_quo_nxt;
            r_div   <= w_div_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_rem_nxt   = r_rem;
        w_quo_nxt   = r_quo;
        w_div_nxt   = r_div;
        done        = 1'b0;
        busy        = (r_state == BUSY);
        quotient    = w_quo_step;
        remainder   = w_rem_step;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = BUSY;
                    w_quo_nxt   = dividend;
                    w_div_nxt   = divisor;
                    w_rem_nxt   = '0;
                    w_count_nxt = '0;
                end
            end
            BUSY: begin
                // Dropping start mid-divide abandons it without producing a result.
                if (!start) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_rem_nxt   = w_rem_step;
                    w_quo_nxt   = w_quo_step;
                    w_count_nxt = r_count + CNT_W'(1);
                    if (r_count == LAST_ITER) begin
                        w_state_nxt = DONE;
                        done        = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!start) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/total_alu.sv
// MIPS-style execute-stage ALU: combinational function mux plus HI/LO fed by the sequential divider.
module total_alu
    import total_alu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [FN_W-1:0]  signal,
    output logic [WIDTH-1:0] dataOut
);

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_start;
    logic             w_div_busy;
    logic             w_div_done;
    logic [WIDTH-1:0] w_div_quo;
    logic [WIDTH-1:0] w_div_rem;

    assign w_start = (signal == FN_DIVU);

    divu_seq u_divu (
        .clk       (clk),
        .reset     (reset),
        .start     (w_start),
        .dividend  (dataA),
        .divisor   (dataB),
        .busy      (w_div_busy),
        .done      (w_div_done),
        .quotient  (w_div_quo),
        .remainder (w_div_rem)
    );

    // HI/LO change only on the edge that retires the final divide iteration.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_div_busy && w_div_done) begin
            r_hi <= w_div_rem;
            r_lo <= w_div_quo;
        end
    end

    always_comb begin
        dataOut = '0;
        case (signal)
            FN_AND:  dataOut = dataA & dataB;
            FN_OR:   dataOut = dataA | dataB;
            FN_ADD:  dataOut = dataA + dataB;
            FN_SUB:  dataOut = dataA - dataB;
            FN_SLT:  dataOut = WIDTH'($signed(dataA) < $signed(dataB));
            FN_SRL:  dataOut = dataA >> dataB[SHAMT_W-1:0];
            FN_MFHI: dataOut = r_hi;
            FN_MFLO: dataOut = r_lo;
            default: dataOut = '0;
        endcase
    end

endmodule

// File: tb/tb_total_alu.sv
// Randomized self-checking bench for total_alu against a plain-arithmetic reference model.
module tb_total_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [5:0]  signal;
    logic [31:0] dataOut;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    always #5 clk = ~clk;

    total_alu dut (
        .clk     (clk),
        .reset   (reset),
        .dataA   (dataA),
        .dataB   (dataB),
        .signal  (signal),
        .dataOut (dataOut)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] hi,
                                            input logic [31:0] lo);
        longint sa;
        longint sb;
        sa = (a >= 32'h8000_0000) ? longint'(a) - 64'sd4294967296 : longint'(a);
        sb = (b >= 32'h8000_0000) ? longint'(b) - 64'sd4294967296 : longint'(b);
        case (op)
            6'd36:   return a & b;
            6'd37:   return a | b;
            6'd32:   return 32'((longint'(a) + longint'(b)) % 64'sd4294967296);
            6'd34:   return 32'((longint'(a) - longint'(b) + 64'sd4294967296) % 64'sd4294967296);
            6'd42:   return (sa < sb) ? 32'd1 : 32'd0;
            6'd2:    return a / (32'd1 << (b % 32));
            6'd16:   return hi;
            6'd18:   return lo;
            default: return 32'd0;
        endcase
    endfunction

    task automatic apply_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                            input string tag);
        @(negedge clk);
        signal = op;
        dataA  = a;
        dataB  = b;
        @(posedge clk);
        #1;
        check(tag, dataOut, ref_alu(op, a, b, m_hi, m_lo));
    endtask

    // Hold DIVU for 'hold' edges while scrambling operands after the load edge, then read HI/LO.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input int hold,
                           input string tag);
        @(negedge clk);
        signal = 6'd27;
        dataA  = a;
        dataB  = b;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            dataA = $urandom;
            dataB = $urandom;
        end
        check({tag, "_out27"}, dataOut, 32'd0);
        if (hold >= 33) begin
            if (b == 32'd0) begin
                m_hi = a;
                m_lo = 32'hFFFF_FFFF;
            end else begin
                m_hi = a % b;
                m_lo = a / b;
            end
        end
        apply_op(6'd16, 32'd0, 32'd0, {tag, "_hi"});
        apply_op(6'd18, 32'd0, 32'd0, {tag, "_lo"});
    endtask

    logic [5:0] ops [8];

    initial begin
        ops = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd2, 6'd16, 6'd18};
        reset  = 1'b1;
        signal = 6'd0;
        dataA  = 32'd0;
        dataB  = 32'd0;
        m_hi   = 32'd0;
        m_lo   = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        apply_op(6'd16, 32'd0, 32'd0, "rst_hi");
        apply_op(6'd18, 32'd0, 32'd0, "rst_lo");

        apply_op(6'd36, 32'd16, 32'd12, "and");
        apply_op(6'd37, 32'd16, 32'd12, "or");
        apply_op(6'd32, 32'd16, 32'd12, "add");
        apply_op(6'd34, 32'd16, 32'd12, "sub");
        apply_op(6'd42, 32'd16, 32'd12, "slt_pos");
        apply_op(6'd42, 32'hFFFF_FFFF, 32'd1, "slt_neg");
        apply_op(6'd32, 32'hFFFF_FFFF, 32'd1, "add_wrap");
        apply_op(6'd34, 32'd0, 32'd1, "sub_wrap");
        apply_op(6'd2, 32'd16, 32'd2, "srl");
        apply_op(6'd2, 32'h8000_0000, 32'd31, "srl_31");
        apply_op(6'd2, 32'd16, 32'd34, "srl_mask");
        apply_op(6'd63, 32'd16, 32'd12, "unknown");

        run_div(32'd16, 32'd5, 35, "div16_5");
        run_div(32'hFFFF_FFFF, 32'd7, 33, "divmax_7");
        run_div(32'd9, 32'd0, 33, "div_by0");
        run_div(32'd20, 32'd6, 33, "div_restart");
        run_div(32'd100, 32'd7, 32, "div_short");
        run_div(32'd1234, 32'd9, 10, "div_abandon");

        // Reset in the middle of a divide clears HI/LO.
        @(negedge clk);
        signal = 6'd27;
        dataA  = 32'd77;
        dataB  = 32'd3;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset  = 1'b1;
        signal = 6'd0;
        @(negedge clk);
        reset = 1'b0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        apply_op(6'd16, 32'd0, 32'd0, "midrst_hi");
        apply_op(6'd18, 32'd0, 32'd0, "midrst_lo");

        for (int i = 0; i < 60; i++) begin
            logic [5:0] op;
            if ($urandom_range(0, 4) == 0) begin
                op = 6'($urandom_range(0, 63));
                if (op == 6'd27) op = 6'd63;
            end else begin
                op = ops[$urandom_range(0, 7)];
            end
            apply_op(op, $urandom, $urandom, $sformatf("rnd%0d_op%0d", i, op));
        end

        for (int i = 0; i < 6; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 255)) : $urandom;
            run_div(a, b, $urandom_range(30, 36), $sformatf("rdiv%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
